// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, multi-cycle FALU hold and flush squash.
// Latency 1 cycle; stall holds IF/ID while a FALU op occupies EX or a load-use bubble is inserted.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int FALU_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [1:0]      id_ALUOp,
  input  logic            id_ALUSrc,
  input  logic            id_Branch,
  input  logic            id_MemWrite,
  input  logic            id_MemRead,
  input  logic            id_MemToReg,
  input  logic            id_RegWrite,
  input  logic            id_FALUEnable,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [1:0]      ex_ALUOp,
  output logic            ex_ALUSrc,
  output logic            ex_Branch,
  output logic            ex_MemWrite,
  output logic            ex_MemRead,
  output logic            ex_MemToReg,
  output logic            ex_RegWrite,
  output logic            ex_FALUEnable,
  output logic            ex_busy
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            mem_write;
    logic            mem_read;
    logic            mem_to_reg;
    logic            reg_write;
    logic            falu_en;
  } ex_t;

  localparam logic [3:0] HOLD_CNT = 4'(FALU_LAT - 1);

  ex_t        id_bundle;
  ex_t        ex_q;
  logic [3:0] cnt;
  logic       load_use;

  always_comb begin
    id_bundle            = '0;
    id_bundle.valid      = 1'b1;
    id_bundle.pc         = id_pc;
    id_bundle.rs1_data   = id_rs1_data;
    id_bundle.rs2_data   = id_rs2_data;
    id_bundle.imm        = id_imm;
    id_bundle.rs1        = id_rs1;
    id_bundle.rs2        = id_rs2;
    id_bundle.rd         = id_rd;
    id_bundle.funct3     = id_funct3;
    id_bundle.funct7     = id_funct7;
    id_bundle.alu_op     = id_ALUOp;
    id_bundle.alu_src    = id_ALUSrc;
    id_bundle.branch     = id_Branch;
    id_bundle.mem_write  = id_MemWrite;
    id_bundle.mem_read   = id_MemRead;
    id_bundle.mem_to_reg = id_MemToReg;
    id_bundle.reg_write  = id_RegWrite;
    id_bundle.falu_en    = id_FALUEnable;
  end

  // x0 is never a real producer, so it cannot create a load-use dependency.
  assign load_use = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != 5'd0) &
                    id_valid & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  assign ex_busy  = (cnt != 4'd0);
  assign stall    = !flush & (ex_busy | load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      cnt  <= 4'd0;
    end else if (flush) begin
      ex_q <= '0;
      cnt  <= 4'd0;
    end else if (ex_busy) begin
      cnt  <= cnt - 4'd1;
    end else if (load_use || !id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_bundle;
      cnt  <= id_FALUEnable ? HOLD_CNT : 4'd0;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_funct7     = ex_q.funct7;
  assign ex_ALUOp      = ex_q.alu_op;
  assign ex_ALUSrc     = ex_q.alu_src;
  assign ex_Branch     = ex_q.branch;
  assign ex_MemWrite   = ex_q.mem_write;
  assign ex_MemRead    = ex_q.mem_read;
  assign ex_MemToReg   = ex_q.mem_to_reg;
  assign ex_RegWrite   = ex_q.reg_write;
  assign ex_FALUEnable = ex_q.falu_en;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the RV32IF core. It captures the decoded operands and the per-opcode control bundle produced by the control unit, and presents them to the execute stage one cycle later. It also detects load-use hazards and inserts bubbles for them. It holds a floating-point instruction in EX for a fixed multi-cycle FALU latency. On a branch/jump flush it squashes the instruction leaving decode.

## Interface
Parameters:
- XLEN, 32, datapath width
- FALU_LAT, 3, total cycles a FALUEnable instruction occupies EX (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  operands / immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3; id_funct7  in  7  ALU control fields
- id_ALUOp  in  2  control bundle: 0 add, 1 sub/branch, 2 R-type, 3 I-type ALU
- id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg, id_RegWrite, id_FALUEnable  in  1 each  control bundle
- flush  in  1  EX resolved a taken branch/jump; squash the ID instruction
- stall  out  1  combinational; IF and ID must hold their contents this cycle
- ex_valid  out  1  EX register holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5; ex_funct3  out  3; ex_funct7  out  7
- ex_ALUOp  out  2; ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemToReg, ex_RegWrite, ex_FALUEnable  out  1 each
- ex_busy  out  1  EX is holding a FALU instruction (hold counter nonzero)

## Operation
- Bubble: ex_valid=0. Every control output is 0 (including MemToReg; X never driven). All data/index outputs are 0.
- Hold counter cnt (4 bits): loaded with FALU_LAT-1 when a valid FALUEnable instruction is loaded into EX. Decrements by 1 each cycle while nonzero. ex_busy = (cnt != 0).
- load_use = ex_valid & ex_MemRead & ex_RegWrite & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Per-cycle next-state, in strict priority order:
  1. flush: EX loads a bubble and cnt is cleared to 0, even if busy.
  2. ex_busy: EX register holds its contents and cnt decrements.
  3. load_use: EX loads a bubble. The ID instruction is retained upstream via stall.
  4. !id_valid: EX loads a bubble.
  5. Otherwise: EX loads all id_* fields, with ex_valid=1.
- stall = !flush & (ex_busy | load_use).
- A flush never asserts stall. The upstream logic squashes ID on flush itself.
- The FALU instruction is the only multi-cycle case. Loads and branches never set cnt.
- rd = x0 never triggers load_use.

## Timing
- Reset (rst_n low, asynchronous): ex_valid=0, all ex_* = 0, cnt=0, ex_busy=0. stall evaluates to 0 because all ex_* are 0.
- Latency: an id_* value sampled at edge N appears on ex_* after edge N (1 cycle).
- A FALU instruction is visible on ex_* for exactly FALU_LAT consecutive cycles. With FALU_LAT=1 there is no hold and ex_busy never asserts.
- stall is asserted for FALU_LAT-1 cycles per FALU instruction.
- load_use produces exactly one bubble. Next cycle EX holds the bubble, so load_use is 0 and ID advances.
- Simultaneous flush and load_use: the flush result applies (bubble) and stall=0.
- Simultaneous flush and busy: the hold is aborted, cnt=0 at the next edge, and the next instruction enters normally one cycle later.
- Reset asserted mid-hold: everything clears immediately. There is no residual stall after rst_n rises.

## Test plan
- Reset: drive garbage on id_*, assert rst_n=0 -> all ex_* = 0, stall=0, ex_busy=0. Release, id_valid=1 ADD rd=5 -> ex_valid=1, ex_rd=5, ex_ALUOp=2 after 1 edge.
- Load-use: LW rd=6 then ADD rs1=6 -> one stall cycle; EX sees LW, then a bubble, then ADD. Repeat with rd=0 -> no stall.
- FALU hold (FALU_LAT=3): FADD.S rd=2 followed by ADD -> ex_FALUEnable=1 for 3 cycles, stall=1 and ex_busy=1 for 2 cycles, ADD enters EX on the 4th cycle.
- Flush vs load-use: LW rd=7 in EX, ADD rs2=7 in ID, flush=1 the same cycle -> stall=0, EX becomes a bubble next cycle.
- Flush during FALU hold: flush in the first busy cycle -> next cycle ex_valid=0, ex_busy=0, stall=0.
- Mid-hold async reset: pull rst_n low between edges in the second busy cycle -> outputs clear without waiting for a clock edge.
